// File: rtl/ctrl_branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg : condition codes, flag indices and condition evaluator. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_N      = 3'd5,
    COND_NN     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;

  function automatic logic cond_true(input cond_e c, input logic [2:0] f);
    case (c)
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = f[FLG_Z];
      COND_NZ:     cond_true = ~f[FLG_Z];
      COND_C:      cond_true = f[FLG_C];
      COND_NC:     cond_true = ~f[FLG_C];
      COND_N:      cond_true = f[FLG_N];
      COND_NN:     cond_true = ~f[FLG_N];
      default:     cond_true = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_branch_resolve_if.sv
// ---------------------------------------------------------------------------
// ctrl_branch_resolve_if : decode-side branch request and PC redirect bundle. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ctrl_branch_resolve_if #(
  parameter int PROG_CTR_WID = 10
);
  logic [PROG_CTR_WID-1:0] prog_ctr;
  logic                    br_en;
  logic [2:0]              br_cond;
  logic                    is_call;
  logic                    is_ret;
  logic [PROG_CTR_WID-1:0] br_target;
  logic                    flag_we;
  logic [2:0]              flags_in;
  logic                    branch_taken_reg;
  logic [PROG_CTR_WID-1:0] nxt_prog_ctr_r2;
  logic                    ras_err;

  modport master (
    output prog_ctr, br_en, br_cond, is_call, is_ret, br_target, flag_we, flags_in,
    input  branch_taken_reg, nxt_prog_ctr_r2, ras_err
  );

  modport slave (
    input  prog_ctr, br_en, br_cond, is_call, is_ret, br_target, flag_we, flags_in,
    output branch_taken_reg, nxt_prog_ctr_r2, ras_err
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_branch_resolve_ras.sv
// ---------------------------------------------------------------------------
// ctrl_ras : circular return-address stack with sticky over/underflow error. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_ras #(
  parameter int WID   = 10,
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  input  wire logic           push_i,
  input  wire logic           pop_i,
  input  wire logic [WID-1:0] push_data_i,
  output logic      [WID-1:0] top_o,
  output logic                empty_o,
  output logic                err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WID-1:0]   stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             w_full;

  assign w_full  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_o   = stack_q[ptr_q - PTR_W'(1)];
  assign err_o   = err_q;

  // ptr_q names the next free slot; it wraps so an overflowing push overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (pop_i) begin
      if (empty_o) begin
        err_q <= 1'b1;
      end else begin
        ptr_q <= ptr_q - PTR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else if (push_i) begin
      stack_q[ptr_q] <= push_data_i;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (w_full) err_q <= 1'b1;
      else        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_branch_resolve.sv
// ---------------------------------------------------------------------------
// ctrl_branch_resolve : two-stage branch resolve, RAS and shadow squash. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_branch_resolve
  import ctrl_pkg::*;
#(
  parameter int PROG_CTR_WID = 10,
  parameter int RAS_DEPTH    = 4,
  parameter int SHADOW_LEN   = 3
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ctrl_branch_resolve_if.slave br_if
);

  localparam int SH_W = (SHADOW_LEN < 1) ? 1 : $clog2(SHADOW_LEN + 1);

  typedef struct packed {
    logic                    valid;
    logic [PROG_CTR_WID-1:0] pc;
    logic                    br_en;
    cond_e                   cond;
    logic                    call;
    logic                    ret;
    logic [PROG_CTR_WID-1:0] tgt;
  } stage_t;

  stage_t                  r1_d, r1_q, r2_q;
  logic [2:0]              flags_q;
  logic [SH_W-1:0]         shadow_d, shadow_q;
  logic                    taken_q;
  logic [PROG_CTR_WID-1:0] npc_d, npc_q;

  logic [2:0]              w_flags;
  logic                    w_take;
  logic                    w_push;
  logic                    w_pop;
  logic [PROG_CTR_WID-1:0] w_ras_top;
  logic                    w_ras_empty;
  logic                    w_ras_err;

  always_comb begin
    r1_d       = '0;
    r1_d.valid = 1'b1;
    r1_d.pc    = br_if.prog_ctr;
    r1_d.br_en = br_if.br_en;
    r1_d.cond  = cond_e'(br_if.br_cond);
    r1_d.call  = br_if.is_call;
    r1_d.ret   = br_if.is_ret;
    r1_d.tgt   = br_if.br_target;
  end

  // Same-cycle ALU flags are forwarded into the r2 condition check
  assign w_flags = br_if.flag_we ? br_if.flags_in : flags_q;
  assign w_take  = r2_q.valid & r2_q.br_en & cond_true(r2_q.cond, w_flags)
                 & (shadow_q == '0);
  assign w_pop   = w_take & r2_q.ret;
  assign w_push  = w_take & r2_q.call & ~r2_q.ret;

  always_comb begin
    npc_d    = npc_q;
    shadow_d = shadow_q;
    if (w_take) begin
      shadow_d = SH_W'(SHADOW_LEN);
      if (r2_q.ret) npc_d = w_ras_empty ? '0 : w_ras_top;
      else          npc_d = r2_q.tgt;
    end else if (shadow_q != '0) begin
      shadow_d = shadow_q - SH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q     <= '0;
      r2_q     <= '0;
      flags_q  <= '0;
      shadow_q <= '0;
      taken_q  <= 1'b0;
      npc_q    <= '0;
    end else begin
      r1_q     <= r1_d;
      r2_q     <= r1_q;
      if (br_if.flag_we) flags_q <= br_if.flags_in;
      shadow_q <= shadow_d;
      taken_q  <= w_take;
      npc_q    <= npc_d;
    end
  end

  ctrl_ras #(
    .WID   (PROG_CTR_WID),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (r2_q.pc + PROG_CTR_WID'(1)),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty),
    .err_o       (w_ras_err)
  );

  assign br_if.branch_taken_reg = taken_q;
  assign br_if.nxt_prog_ctr_r2  = npc_q;
  assign br_if.ras_err          = w_ras_err;

endmodule

`default_nettype wire

// File: doc/ctrl_branch_resolve.md
Name: ctrl_branch_resolve

Overview:
- Producer side of the program-counter redirect interface.
- Carries each fetched instruction's PC and decoded branch request through two pipeline registers (r1 decode, r2 execute).
- Evaluates the branch condition against the ALU flags and drives the registered `branch_taken_reg` / `nxt_prog_ctr_r2` pair consumed by the program counter.
- Holds a small return-address stack for call/return, and squashes branch requests from wrong-path instructions in the branch shadow.

Parameters:
- PROG_CTR_WID, 10, width of all PC and target values.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- SHADOW_LEN, 3, cycles of branch-request squash after a taken branch.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- prog_ctr  in  PROG_CTR_WID  PC of instruction entering r1 this cycle.
- br_en  in  1  instruction is a branch/call/return.
- br_cond  in  3  condition code (see Behaviour).
- is_call  in  1  branch also pushes return address.
- is_ret  in  1  target comes from RAS top; br_target ignored.
- br_target  in  PROG_CTR_WID  absolute target from decoder.
- flag_we  in  1  flags_in valid this cycle.
- flags_in  in  3  {neg, carry, zero} from ALU.
- branch_taken_reg  out  1  one-cycle redirect strobe to program counter.
- nxt_prog_ctr_r2  out  PROG_CTR_WID  redirect target, valid when branch_taken_reg=1.
- ras_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - r1/r2 valid bits 0, flags 0.
  - RAS pointer 0, count 0.
  - Shadow counter 0.
- r1 captures {prog_ctr, br_en, br_cond, is_call, is_ret, br_target} every cycle; r1 → r2 every cycle. No stall input.
- Flag register:
  - Loads flags_in when flag_we=1.
  - Condition evaluation in r2 uses flags_in when flag_we=1 the same cycle (forwarding), otherwise the flag register.
- br_cond:
  - 0 always
  - 1 Z
  - 2 NZ
  - 3 C
  - 4 NC
  - 5 N
  - 6 NN
  - 7 never
- Take condition: r2.br_en=1 and condition true and shadow counter=0. This is evaluated in cycle T, registered, and appears at the outputs in cycle T+1:
  - branch_taken_reg=1 for exactly one cycle.
  - nxt_prog_ctr_r2 = RAS top if r2.is_ret, else r2.br_target.
  - branch_taken_reg=0 in every cycle where no take occurred.
  - nxt_prog_ctr_r2 holds its last value when not taken.
- Shadow:
  - On a take, the shadow counter loads SHADOW_LEN.
  - It decrements each cycle to 0.
  - While it is nonzero, r2 branch requests are ignored, including call pushes and ret pops.
- Call:
  - A taken is_call pushes r2.pc + 1 (mod 2^PROG_CTR_WID).
  - Pointer wraps; the oldest entry is overwritten.
  - If the count is already RAS_DEPTH, ras_err is set.
- Return:
  - A taken is_ret pops.
  - If the RAS is empty, the target is 0 and ras_err is set.
- is_call and is_ret both 1: treated as a return only.
- ras_err clears only on reset.
- Reset mid-shadow or mid-branch: all state cleared the next cycle, and no pending redirect is emitted.

Decomposition:
- Shared package ctrl_pkg:
  - Condition code constants COND_ALWAYS..COND_NEVER.
  - Flag bit indices FLG_Z=0, FLG_C=1, FLG_N=2.
- Natural sub-module: ctrl_ras (push/pop/top/empty/full/err), instantiated once.

Test Plan:
- Unconditional jump: r2 with br_en=1, cond=0, target=0x155 at cycle T → branch_taken_reg=1, nxt_prog_ctr_r2=0x155 at T+1; branch_taken_reg=0 at T+2.
- BZ with flags Z=0, then BZ with flag_we=1, flags_in=001 in the same cycle → first not taken; second taken (forwarding).
- Shadow: taken jump followed by branches in the next 3 cycles → only the first redirects; a branch in cycle 4 after the take redirects.
- Call/return: call at pc=0x010 → target 0x080; ret 4+ cycles later → nxt_prog_ctr_r2=0x011.
- RAS: 5 calls with RAS_DEPTH=4 → ras_err=1. After reset, a ret on empty RAS → target 0x000, ras_err=1.
- Reset asserted the cycle a take is evaluated → branch_taken_reg stays 0, all outputs 0.
